// File: rtl/eq2_bist_sequencer_if.sv
// Bus bundle between the eq2 BIST sequencer and its environment:
// stimulus/response pins of the comparator plus run control and result reporting.
interface eq2_bist_sequencer_if #(
    parameter int ERR_W = 5
);
    // start is a level request, accepted only on an IDLE edge (no ready; extra starts are dropped);
    // done is a one-cycle completion pulse, and results stay valid until the next accepted start.
    logic             start;
    logic             aeqb;
    logic [1:0]       a;
    logic [1:0]       b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic             fail_valid;
    logic [3:0]       first_fail_vec;
    logic [1:0]       state_dbg;

    modport master (
        input  start, aeqb,
        output a, b, busy, done, pass, err_cnt, fail_valid, first_fail_vec, state_dbg
    );

    modport slave (
        output start, aeqb,
        input  a, b, busy, done, pass, err_cnt, fail_valid, first_fail_vec, state_dbg
    );
endinterface

// File: rtl/eq2_bist_sequencer.sv
// Walks all 16 {a,b} vectors through an eq2 comparator, holding each for HOLD_CYCLES
// before sampling aeqb, and reports error count, pass and the first failing vector.
module eq2_bist_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    eq2_bist_sequencer_if.master  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic [3:0]       idx_q, idx_d;
    logic [1:0]       a_q, a_d;
    logic [1:0]       b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             fail_valid_q, fail_valid_d;
    logic [3:0]       first_fail_vec_q, first_fail_vec_d;

    logic expect_eq;
    logic mismatch;

    assign expect_eq = (idx_q[3:2] == idx_q[1:0]);
    assign mismatch  = (bus.aeqb != expect_eq);

    always_comb begin
        state_d          = state_q;
        hold_d           = hold_q;
        idx_d            = idx_q;
        a_d              = a_q;
        b_d              = b_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        pass_d           = pass_q;
        err_cnt_d        = err_cnt_q;
        fail_valid_d     = fail_valid_q;
        first_fail_vec_d = first_fail_vec_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d          = S_DRIVE;
                    hold_d           = HOLD_RELOAD;
                    idx_d            = 4'd0;
                    a_d              = 2'd0;
                    b_d              = 2'd0;
                    busy_d           = 1'b1;
                    pass_d           = 1'b0;
                    err_cnt_d        = '0;
                    fail_valid_d     = 1'b0;
                    first_fail_vec_d = 4'd0;
                end
            end
            S_DRIVE: begin
                if (hold_q == 8'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d     = 1'b1;
                        first_fail_vec_d = idx_q;
                    end
                end
                if (idx_q == 4'd15) begin
                    // pass is settled together with the final error count so it is valid alongside done
                    state_d = S_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    a_d     = 2'd0;
                    b_d     = 2'd0;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    state_d = S_DRIVE;
                    idx_d   = idx_q + 4'd1;
                    hold_d  = HOLD_RELOAD;
                    a_d     = idx_d[3:2];
                    b_d     = idx_d[1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            hold_q           <= 8'd0;
            idx_q            <= 4'd0;
            a_q              <= 2'd0;
            b_q              <= 2'd0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_cnt_q        <= '0;
            fail_valid_q     <= 1'b0;
            first_fail_vec_q <= 4'd0;
        end else begin
            state_q          <= state_d;
            hold_q           <= hold_d;
            idx_q            <= idx_d;
            a_q              <= a_d;
            b_q              <= b_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            err_cnt_q        <= err_cnt_d;
            fail_valid_q     <= fail_valid_d;
            first_fail_vec_q <= first_fail_vec_d;
        end
    end

    assign bus.a              = a_q;
    assign bus.b              = b_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_cnt        = err_cnt_q;
    assign bus.fail_valid     = fail_valid_q;
    assign bus.first_fail_vec = first_fail_vec_q;
    assign bus.state_dbg      = state_q;
endmodule

// File: tb/tb_eq2_bist_sequencer.sv
// Bench for eq2_bist_sequencer: two instances (HOLD_CYCLES 4 and 1) against a run-position model.
module tb_eq2_bist_sequencer;
    localparam int ERR_W   = 5;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
    localparam int H0      = 4;
    localparam int H1      = 1;
    localparam int SBW     = ERR_W + 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic       start0, start1;
    logic [1:0] mode0, mode1;   // 0 ideal eq2, 1 tied 0, 2 tied 1, 3 random
    logic       rnd0, rnd1;
    logic       aeqb0, aeqb1;

    eq2_bist_sequencer_if #(.ERR_W(ERR_W)) bus0 ();
    eq2_bist_sequencer_if #(.ERR_W(ERR_W)) bus1 ();

    assign bus0.start = start0;
    assign bus1.start = start1;
    assign bus0.aeqb  = aeqb0;
    assign bus1.aeqb  = aeqb1;
    assign aeqb0 = (mode0 == 2'd0) ? (bus0.a == bus0.b) :
                   (mode0 == 2'd1) ? 1'b0 : (mode0 == 2'd2) ? 1'b1 : rnd0;
    assign aeqb1 = (mode1 == 2'd0) ? (bus1.a == bus1.b) :
                   (mode1 == 2'd1) ? 1'b0 : (mode1 == 2'd2) ? 1'b1 : rnd1;

    eq2_bist_sequencer #(.HOLD_CYCLES(H0), .ERR_W(ERR_W)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );
    eq2_bist_sequencer #(.HOLD_CYCLES(H1), .ERR_W(ERR_W)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    // ---------------- model state ----------------
    int         hold_m [2] = '{H0, H1};
    bit         run_m  [2];
    int         p_m    [2];
    int         err_m  [2];
    bit         pass_m [2];
    bit         fv_m   [2];
    bit         done_m [2];
    logic [3:0] ffv_m  [2];
    int         busy_n [2];
    int         done_n [2];
    logic [SBW-1:0] exp_q0[$];
    logic [SBW-1:0] exp_q1[$];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // p counts cycles since the accepted start; cycle p shows vector p/(H+1),
    // and the last cycle of each vector slot is the one whose aeqb gets judged.
    task automatic model_step(int i, logic st, logic aq);
        int   per;
        int   v;
        bit   was_done;
        logic expv;
        per      = hold_m[i] + 1;
        was_done = done_m[i];
        done_m[i] = 1'b0;
        if (reset_n !== 1'b1) begin
            run_m[i] = 0; p_m[i] = 0; err_m[i] = 0;
            pass_m[i] = 0; fv_m[i] = 0; ffv_m[i] = 4'd0;
            return;
        end
        if (run_m[i]) begin
            if ((p_m[i] % per) == hold_m[i]) begin
                v    = p_m[i] / per;
                expv = ((v / 4) == (v % 4));
                if (aq !== expv) begin
                    if (err_m[i] < ERR_MAX) err_m[i]++;
                    if (!fv_m[i]) begin
                        fv_m[i]  = 1'b1;
                        ffv_m[i] = v[3:0];
                    end
                end
            end
            p_m[i]++;
            if (p_m[i] == 16 * per) begin
                run_m[i]  = 1'b0;
                done_m[i] = 1'b1;
                pass_m[i] = (err_m[i] == 0);
                if (i == 0) exp_q0.push_back({pass_m[i], ERR_W'(err_m[i]), fv_m[i], ffv_m[i]});
                else        exp_q1.push_back({pass_m[i], ERR_W'(err_m[i]), fv_m[i], ffv_m[i]});
            end
        end else if (!was_done && st === 1'b1) begin
            run_m[i] = 1'b1; p_m[i] = 0; err_m[i] = 0;
            pass_m[i] = 1'b0; fv_m[i] = 1'b0; ffv_m[i] = 4'd0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step(0, start0, aeqb0);
            model_step(1, start1, aeqb1);
        end
    end

    // ---------------- per-cycle compare + scoreboard ----------------
    task automatic cmp(int i, logic [1:0] a, logic [1:0] b, logic busy, logic done, logic pass,
                       logic [ERR_W-1:0] err, logic fv, logic [3:0] ffv);
        int v;
        logic [SBW-1:0] e;
        v = run_m[i] ? (p_m[i] / (hold_m[i] + 1)) : 0;
        chk($sformatf("u%0d.a", i), 32'(a), 32'(v / 4));
        chk($sformatf("u%0d.b", i), 32'(b), 32'(v % 4));
        chk($sformatf("u%0d.busy", i), 32'(busy), 32'(run_m[i]));
        chk($sformatf("u%0d.done", i), 32'(done), 32'(done_m[i]));
        chk($sformatf("u%0d.pass", i), 32'(pass), 32'(pass_m[i]));
        chk($sformatf("u%0d.err_cnt", i), 32'(err), 32'(err_m[i]));
        chk($sformatf("u%0d.fail_valid", i), 32'(fv), 32'(fv_m[i]));
        chk($sformatf("u%0d.first_fail_vec", i), 32'(ffv), 32'(ffv_m[i]));
        if (busy === 1'b1) busy_n[i]++;
        if (done === 1'b1) begin
            done_n[i]++;
            if (i == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
            else if (i == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
            else e = 'x;
            chk($sformatf("u%0d.sb_result", i), 32'({pass, err, fv, ffv}), 32'(e));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                cmp(0, bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass, bus0.err_cnt,
                    bus0.fail_valid, bus0.first_fail_vec);
                cmp(1, bus1.a, bus1.b, bus1.busy, bus1.done, bus1.pass, bus1.err_cnt,
                    bus1.fail_valid, bus1.first_fail_vec);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(bit s0, bit s1);
        busy_n[0] = 0; busy_n[1] = 0; done_n[0] = 0; done_n[1] = 0;
        start0 = s0; start1 = s1;
        tick();
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic wait_done(int i, int limit);
        logic d;
        for (int n = 0; n < limit; n++) begin
            d = (i == 0) ? bus0.done : bus1.done;
            if (d === 1'b1) break;
            tick();
        end
        d = (i == 0) ? bus0.done : bus1.done;
        chk($sformatf("u%0d.wait_done", i), 32'(d), 32'd1);
        tick();
        tick();
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        mode0 = 2'd0; mode1 = 2'd0; rnd0 = 1'b0; rnd1 = 1'b0;
        tick();
        chk_en = 1'b1;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("reset.busy", 32'(bus0.busy), 32'd0);
        chk("reset.ab", 32'({bus0.a, bus0.b}), 32'd0);
        chk("reset.err_cnt", 32'(bus0.err_cnt), 32'd0);
        chk("reset.pass", 32'(bus0.pass), 32'd0);

        // clean run on both instances
        start_run(1, 1);
        wait_done(0, 200);
        chk("ideal.busy_cycles", 32'(busy_n[0]), 32'd80);
        chk("ideal.done_count", 32'(done_n[0]), 32'd1);
        chk("ideal.err_cnt", 32'(bus0.err_cnt), 32'd0);
        chk("ideal.pass", 32'(bus0.pass), 32'd1);
        chk("ideal.fail_valid", 32'(bus0.fail_valid), 32'd0);
        chk("h1.busy_cycles", 32'(busy_n[1]), 32'd32);
        chk("h1.pass", 32'(bus1.pass), 32'd1);

        // aeqb stuck low
        mode0 = 2'd1;
        start_run(1, 0);
        wait_done(0, 200);
        chk("tie0.err_cnt", 32'(bus0.err_cnt), 32'd4);
        chk("tie0.pass", 32'(bus0.pass), 32'd0);
        chk("tie0.fail_valid", 32'(bus0.fail_valid), 32'd1);
        chk("tie0.first_fail_vec", 32'(bus0.first_fail_vec), 32'd0);

        // aeqb stuck high
        mode0 = 2'd2;
        start_run(1, 0);
        wait_done(0, 200);
        chk("tie1.err_cnt", 32'(bus0.err_cnt), 32'd12);
        chk("tie1.pass", 32'(bus0.pass), 32'd0);
        chk("tie1.first_fail_vec", 32'(bus0.first_fail_vec), 32'd1);

        // extra start pulses during a run are dropped
        mode0 = 2'd1;
        start_run(1, 0);
        for (int c = 1; c <= 90; c++) begin
            start0 = (c == 10 || c == 50);
            tick();
        end
        start0 = 1'b0;
        chk("repulse.done_count", 32'(done_n[0]), 32'd1);
        chk("repulse.busy_cycles", 32'(busy_n[0]), 32'd80);
        chk("repulse.err_cnt", 32'(bus0.err_cnt), 32'd4);
        mode0 = 2'd0;
        start_run(1, 0);
        chk("restart.err_cleared", 32'(bus0.err_cnt), 32'd0);
        wait_done(0, 200);
        chk("restart.pass", 32'(bus0.pass), 32'd1);

        // reset in the middle of a run
        start_run(1, 0);
        repeat (29) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midreset.busy", 32'(bus0.busy), 32'd0);
        chk("midreset.ab", 32'({bus0.a, bus0.b}), 32'd0);
        done_n[0] = 0;
        repeat (100) tick();
        chk("midreset.no_done", 32'(done_n[0]), 32'd0);
        start_run(1, 0);
        wait_done(0, 200);
        chk("postreset.busy_cycles", 32'(busy_n[0]), 32'd80);
        chk("postreset.pass", 32'(bus0.pass), 32'd1);

        // short hold instance alone
        mode1 = 2'd0;
        start_run(0, 1);
        wait_done(1, 100);
        chk("h1solo.busy_cycles", 32'(busy_n[1]), 32'd32);
        chk("h1solo.err_cnt", 32'(bus1.err_cnt), 32'd0);
        chk("h1solo.pass", 32'(bus1.pass), 32'd1);

        // random starts, responses and occasional resets
        for (int c = 0; c < 1600; c++) begin
            if (c % 100 == 0) begin
                mode0 = 2'($urandom_range(0, 3));
                mode1 = 2'($urandom_range(0, 3));
            end
            start0  = ($urandom_range(0, 7) == 0);
            start1  = ($urandom_range(0, 7) == 0);
            rnd0    = 1'($urandom_range(0, 1));
            rnd1    = 1'($urandom_range(0, 1));
            reset_n = ($urandom_range(0, 399) != 0);
            tick();
        end
        start0 = 1'b0; start1 = 1'b0; reset_n = 1'b1;
        repeat (100) tick();
        chk("sb.q0_drained", 32'(exp_q0.size()), 32'd0);
        chk("sb.q1_drained", 32'(exp_q1.size()), 32'd0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/eq2_bist_sequencer.md
Name: eq2_bist_sequencer

Overview:
- Self-checking stimulus/response stage wrapped around the 2-bit equality comparator (eq2).
- On a start request it drives all 16 {a,b} combinations into eq2's a/b inputs and samples eq2's aeqb output.
- Checks each sample against the expected (a==b) result and reports pass/fail, error count and first failing vector.
- Sits directly upstream and downstream of eq2; used for on-board self-test and as a synthesizable replacement for hand-written vector lists.

Parameters:
- HOLD_CYCLES, 4, cycles each vector is held on a/b before aeqb is sampled; legal range 1..255.
- ERR_W, 5, width of error counter; must be >= 5 so it can count all 16 vectors.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE.
- a  out  2  comparator operand a, drives eq2.a.
- b  out  2  comparator operand b, drives eq2.b.
- aeqb  in  1  comparator result from eq2.aeqb.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  high when the last completed run had zero errors.
- err_cnt  out  ERR_W  mismatches in the current/last run.
- fail_valid  out  1  first_fail_vec holds a captured failure.
- first_fail_vec  out  4  {a,b} of the first mismatching vector.

Behaviour:
- Reset (reset_n low at a clk edge): state=IDLE; a=b=0; busy=0; done=0; pass=0; err_cnt=0; fail_valid=0; first_fail_vec=0; internal hold counter and 4-bit vector index idx=0. Reset wins over every other event, including mid-run. No done pulse follows an aborted run.
- Vector mapping: a=idx[3:2], b=idx[1:0]; idx steps 0..15 in order. a/b are registered outputs.
- FSM states: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE:
  - a=b=0, busy=0.
  - On start=1 at an edge: go to DRIVE; clear err_cnt, fail_valid, first_fail_vec and pass; set idx=0 and hold counter=HOLD_CYCLES-1.
- DRIVE:
  - busy=1. a/b present idx.
  - Hold counter decrements each cycle; when it reaches 0, go to SAMPLE next cycle.
  - DRIVE therefore lasts exactly HOLD_CYCLES cycles per vector.
- SAMPLE (1 cycle):
  - busy=1, a/b unchanged. aeqb is compared with expected = (idx[3:2]==idx[1:0]).
  - On mismatch: err_cnt increments, saturating at all-ones. If fail_valid=0, capture first_fail_vec=idx and set fail_valid=1.
  - If idx==15, go to FINISH. Otherwise increment idx, reload hold counter, and return to DRIVE.
- FINISH (1 cycle):
  - busy=0, done=1, a=b=0.
  - pass=1 if err_cnt==0.
  - Return to IDLE.
- Latency: start accepted at edge k → busy high for exactly 16*(HOLD_CYCLES+1) cycles → done high in the following cycle. Default: 80 busy cycles, done in cycle 81.
- start is ignored while busy or in FINISH; no queuing.
- err_cnt, pass, fail_valid and first_fail_vec hold their values after a run until the next accepted start or reset.
- aeqb is treated as combinational from a/b. Any settling up to HOLD_CYCLES cycles is tolerated; only the SAMPLE-cycle value is checked.
- Exactly 4 of the 16 vectors expect aeqb=1 (idx 0, 5, 10, 15).

Test Plan:
- Ideal eq2 attached, HOLD_CYCLES=4, pulse start → busy high 80 cycles, done pulses once in cycle 81, err_cnt=0, pass=1, fail_valid=0, a/b walk 00/00 … 11/11.
- aeqb tied 0 → err_cnt=4, pass=0, fail_valid=1, first_fail_vec=4'b0000.
- aeqb tied 1 → err_cnt=12, pass=0, first_fail_vec=4'b0001.
- start re-pulsed at cycles 10 and 50 of a run → ignored; a single done at cycle 81; a second start after done restarts with err_cnt cleared; a back-to-back clean run gives pass=1.
- reset_n low for one cycle at cycle 30 of a run → next cycle all outputs at reset values, state IDLE, no done pulse; a fresh start then completes normally.
- HOLD_CYCLES=1 with ideal eq2 → busy for 32 cycles, each vector held 2 cycles, err_cnt=0, pass=1.
